// File: rtl/divclk_edge_monitor.sv
// rtl/divclk_edge_monitor.sv - divided-clock edge strobes, half-period measurement and lock FSM
module divclk_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int EXP_HALF    = 4,
    parameter int TOL         = 0,
    parameter int LOCK_COUNT  = 4,
    parameter int LOSS_COUNT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk_in,
    input  logic             en,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic [7:0]       err_count
);

    localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int BW = (LOSS_COUNT < 2) ? 1 : $clog2(LOSS_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   EXP_W     = (CNT_W + 1)'(EXP_HALF);
    localparam logic [CNT_W:0]   TOL_W     = (CNT_W + 1)'(TOL);
    localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0]    BAD_LAST  = BW'(LOSS_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_hist;
    logic [CNT_W-1:0]       cnt;
    logic                   seen_edge;
    logic [GW-1:0]          good_cnt;
    logic [BW-1:0]          bad_cnt;

    logic             sync_lvl;
    logic             run;
    logic             rise_det;
    logic             fall_det;
    logic             strobe;
    logic             meas_valid;
    logic             timeout;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   diff;
    logic             meas_good;
    logic             good_event;
    logic             bad_event;
    logic             lock_hit;
    logic             loss_hit;

    // Edge detection compares the last synchroniser stage against the history flop.
    // Everything downstream of the edge is gated by run so IDLE produces no events.
    assign sync_lvl   = sync_q[SYNC_STAGES-1];
    assign run        = en && (state != ST_IDLE);
    assign rise_det   = run && sync_lvl && !edge_hist;
    assign fall_det   = run && !sync_lvl && edge_hist;
    assign strobe     = rise_det || fall_det;
    assign meas_valid = strobe && seen_edge;

    // A strobe on the same cycle as a full counter wins, so timeout excludes it.
    assign timeout    = run && !strobe && (cnt == CNT_MAX);

    // Distance from the expected half-period, one bit wider so the subtraction never wraps.
    assign cnt_ext    = {1'b0, cnt};
    assign diff       = (cnt_ext >= EXP_W) ? (cnt_ext - EXP_W) : (EXP_W - cnt_ext);
    assign meas_good  = (diff <= TOL_W);

    // A timeout counts as a bad measurement even though it reports no period.
    assign good_event = meas_valid && meas_good;
    assign bad_event  = (meas_valid && !meas_good) || timeout;

    assign lock_hit   = (state == ST_ACQUIRE) && good_event && (good_cnt == GOOD_LAST);
    assign loss_hit   = (state == ST_LOCKED) && bad_event && (bad_cnt == BAD_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: en low parks the monitor in IDLE from any state.
    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_next = ST_ACQUIRE;
                ST_ACQUIRE: if (lock_hit) state_next = ST_LOCKED;
                ST_LOCKED:  if (loss_hit) state_next = ST_ACQUIRE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: locked is a pure decode of the state register.
    always_comb begin
        locked = (state == ST_LOCKED);
    end

    // Synchroniser chain and edge history keep running in every state, so
    // re-enabling never sees a stale level as a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            edge_hist <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], div_clk_in};
            edge_hist <= sync_lvl;
        end
    end

    // Registered strobes and the measurement result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            period_valid <= 1'b0;
            half_period  <= '0;
        end else begin
            rise_pulse   <= rise_det;
            fall_pulse   <= fall_det;
            period_valid <= meas_valid;
            if (meas_valid) begin
                half_period <= cnt;
            end
        end
    end

    // Run counter: distance since the last strobe; a timeout restarts it and
    // forgets the previous edge so the next strobe only re-arms measurement.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt       <= '0;
            seen_edge <= 1'b0;
        end else if (strobe) begin
            cnt       <= CNT_W'(1);
            seen_edge <= 1'b1;
        end else if (timeout) begin
            cnt       <= CNT_W'(1);
            seen_edge <= 1'b0;
        end else begin
            cnt       <= cnt + CNT_W'(1);
        end
    end

    // Consecutive good/bad measurement counters driving lock entry and loss.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            case (state)
                ST_ACQUIRE: begin
                    if (lock_hit) begin
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end else if (good_event) begin
                        good_cnt <= good_cnt + GW'(1);
                    end else if (bad_event) begin
                        good_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (loss_hit) begin
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end else if (good_event) begin
                        bad_cnt <= '0;
                    end else if (bad_event) begin
                        bad_cnt <= bad_cnt + BW'(1);
                    end
                end
                default: begin
                    good_cnt <= '0;
                    bad_cnt  <= '0;
                end
            endcase
        end
    end

    // Error strobe and saturating error count; the count survives en toggles.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err_pulse <= (state == ST_LOCKED) && bad_event;
            if ((state == ST_LOCKED) && bad_event && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_divclk_edge_monitor.sv
// tb/tb_divclk_edge_monitor.sv - self-checking bench for divclk_edge_monitor
module tb_divclk_edge_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       div_clk_in;
    logic       en;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] half_period;
    logic       period_valid;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;

    divclk_edge_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .div_clk_in   (div_clk_in),
        .en           (en),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .half_period  (half_period),
        .period_valid (period_valid),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int tcount = 0;
    int n_rise, n_fall, n_both, n_pv, n_err, lock_pv, first_strobe_pv, last_strobe_t;

    typedef struct {
        int half;
        int ntog;
        int pv;
        int rise;
        int fall;
        int hp;
        int lk;
        int lock_pv;
    } vec_t;

    vec_t vecs[6];

    localparam int NT   = 64;
    localparam int MAXC = 1024;
    int L[NT];
    int s[NT];
    bit e_rise[MAXC];
    bit e_fall[MAXC];
    bit e_pv[MAXC];
    bit e_err[MAXC];
    int e_hpv[MAXC];
    int e_lkv[MAXC];
    int e_ecv[MAXC];
    int e_hp[MAXC];
    int e_lk[MAXC];
    int e_ec[MAXC];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0d)", name, act, exp, tcount);
        end
    endtask

    task automatic clear_stats();
        n_rise = 0; n_fall = 0; n_both = 0; n_pv = 0; n_err = 0;
        lock_pv = 0; first_strobe_pv = -1; last_strobe_t = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tcount++;
        if (rise_pulse) n_rise++;
        if (fall_pulse) n_fall++;
        if (rise_pulse && fall_pulse) n_both++;
        if (rise_pulse || fall_pulse) begin
            if (first_strobe_pv < 0) first_strobe_pv = int'(period_valid);
            last_strobe_t = tcount;
        end
        if (period_valid) n_pv++;
        if (err_pulse) n_err++;
        if (locked && lock_pv == 0) lock_pv = n_pv;
    endtask

    task automatic start();
        rst = 1'b1; en = 1'b0; div_clk_in = 1'b0;
        tick(); tick();
        rst = 1'b0; en = 1'b1;
        repeat (3) tick();
        clear_stats();
    endtask

    task automatic toggles(input int half, input int n);
        for (int i = 0; i < n; i++) begin
            div_clk_in = ~div_clk_in;
            repeat (half) tick();
        end
    endtask

    task automatic wait_err(input int bound);
        for (int i = 0; i < bound && !err_pulse; i++) tick();
    endtask

    initial begin
        int t0, t1, c, r, lk, good_run, bad_run, ec, cur_hp, cur_lk, cur_ec, nc;

        vecs[0] = '{4, 10, 9, 5, 5, 4, 1, 4};
        vecs[1] = '{5,  8, 7, 4, 4, 5, 0, 0};
        vecs[2] = '{3,  7, 6, 4, 3, 3, 0, 0};
        vecs[3] = '{4,  4, 3, 2, 2, 4, 0, 0};
        vecs[4] = '{4,  5, 4, 3, 2, 4, 1, 4};
        vecs[5] = '{6,  5, 4, 3, 2, 6, 0, 0};

        // Reset state
        rst = 1'b1; en = 1'b0; div_clk_in = 1'b1;
        clear_stats();
        tick(); tick();
        chk("rst_rise", rise_pulse, 0);
        chk("rst_fall", fall_pulse, 0);
        chk("rst_hp", half_period, 0);
        chk("rst_pv", period_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_count", err_count, 0);

        // Table-driven steady waveforms
        foreach (vecs[k]) begin
            start();
            toggles(vecs[k].half, vecs[k].ntog);
            repeat (4) tick();
            chk("vec_pv_count", n_pv, vecs[k].pv);
            chk("vec_rise_count", n_rise, vecs[k].rise);
            chk("vec_fall_count", n_fall, vecs[k].fall);
            chk("vec_half_period", half_period, vecs[k].hp);
            chk("vec_locked", locked, vecs[k].lk);
            chk("vec_lock_at_pv", lock_pv, vecs[k].lock_pv);
            chk("vec_err_count", err_count, 0);
            chk("vec_err_pulses", n_err, 0);
            chk("vec_both_strobes", n_both, 0);
        end

        // Edge latency: step sampled at E0 gives rise_pulse only at E0+2
        start();
        div_clk_in = 1'b1;
        tick(); chk("lat_e0", rise_pulse, 0);
        tick(); chk("lat_e1", rise_pulse, 0);
        tick(); chk("lat_e2", rise_pulse, 1);
        chk("lat_e2_pv", period_valid, 0);
        tick(); chk("lat_e3", rise_pulse, 0);
        repeat (6) tick();
        chk("lat_rise_count", n_rise, 1);
        chk("lat_fall_count", n_fall, 0);

        // Timeouts while locked
        start();
        toggles(4, 6);
        chk("to_locked_pre", locked, 1);
        t0 = last_strobe_t;
        wait_err(600);
        chk("to1_seen", err_pulse, 1);
        chk("to1_delay", tcount - t0, 255);
        chk("to1_err_count", err_count, 1);
        chk("to1_locked", locked, 1);
        chk("to1_no_pv", period_valid, 0);
        t1 = tcount;
        tick();
        wait_err(600);
        chk("to2_seen", err_pulse, 1);
        chk("to2_delay", tcount - t1, 255);
        chk("to2_err_count", err_count, 2);
        chk("to2_locked", locked, 0);

        // en drop for one cycle while locked, then relock
        clear_stats();
        toggles(4, 6);
        chk("en_locked_pre", locked, 1);
        chk("en_err_pre", err_count, 2);
        div_clk_in = ~div_clk_in;
        tick(); tick();
        en = 1'b0;
        tick();
        chk("en_idle_locked", locked, 0);
        chk("en_idle_rise", rise_pulse, 0);
        chk("en_idle_fall", fall_pulse, 0);
        en = 1'b1;
        tick();
        chk("en_back_rise", rise_pulse, 0);
        chk("en_back_fall", fall_pulse, 0);
        clear_stats();
        repeat (3) tick();
        chk("en_no_late_strobe", n_rise + n_fall, 0);
        toggles(4, 5);
        repeat (4) tick();
        chk("en_first_strobe_pv", first_strobe_pv, 0);
        chk("en_pv_count", n_pv, 4);
        chk("en_relocked", locked, 1);
        chk("en_relock_at_pv", lock_pv, 4);
        chk("en_err_held", err_count, 2);

        // Reset mid-LOCKED with input high
        rst = 1'b1; div_clk_in = 1'b1;
        tick();
        chk("mrst_rise", rise_pulse, 0);
        chk("mrst_fall", fall_pulse, 0);
        chk("mrst_hp", half_period, 0);
        chk("mrst_pv", period_valid, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_err_pulse", err_pulse, 0);
        chk("mrst_err_count", err_count, 0);
        rst = 1'b0;
        clear_stats();
        tick(); tick(); tick();
        chk("mrst_rise_e2", rise_pulse, 1);
        chk("mrst_pv_e2", period_valid, 0);
        repeat (5) tick();
        chk("mrst_rise_count", n_rise, 1);
        chk("mrst_fall_count", n_fall, 0);
        chk("mrst_pv_count", n_pv, 0);

        // Randomized half-periods against an event-time reference model
        for (int i = 0; i < NT; i++) begin
            r = int'($urandom_range(0, 9));
            L[i] = (r < 6) ? 4 : (r == 6) ? 3 : (r == 7) ? 5 : (r == 8) ? 6 : 5;
        end
        for (int i = 0; i < MAXC; i++) begin
            e_rise[i] = 0; e_fall[i] = 0; e_pv[i] = 0; e_err[i] = 0;
            e_hpv[i] = 0; e_lkv[i] = 0; e_ecv[i] = 0;
        end
        s[0] = 1;
        for (int i = 1; i < NT; i++) s[i] = s[i-1] + L[i-1];
        nc = s[NT-1] + L[NT-1] - 1;
        lk = 0; good_run = 0; bad_run = 0; ec = 0;
        for (int i = 0; i < NT; i++) begin
            int t;
            t = s[i] + 2;
            if (i % 2 == 0) e_rise[t] = 1; else e_fall[t] = 1;
            if (i > 0) begin
                int m;
                m = s[i] - s[i-1];
                e_pv[t] = 1;
                e_hpv[t] = m;
                if (!lk) begin
                    if (m == 4) begin
                        good_run++;
                        if (good_run == 4) begin lk = 1; good_run = 0; bad_run = 0; end
                    end else begin
                        good_run = 0;
                    end
                end else begin
                    if (m == 4) begin
                        bad_run = 0;
                    end else begin
                        bad_run++;
                        e_err[t] = 1;
                        if (ec < 255) ec++;
                        if (bad_run == 2) begin lk = 0; good_run = 0; bad_run = 0; end
                    end
                end
                e_lkv[t] = lk;
                e_ecv[t] = ec;
            end
        end
        cur_hp = 0; cur_lk = 0; cur_ec = 0;
        for (int k = 1; k <= nc; k++) begin
            if (e_pv[k]) begin cur_hp = e_hpv[k]; cur_lk = e_lkv[k]; cur_ec = e_ecv[k]; end
            e_hp[k] = cur_hp; e_lk[k] = cur_lk; e_ec[k] = cur_ec;
        end

        start();
        c = 0;
        for (int i = 0; i < NT; i++) begin
            div_clk_in = ~div_clk_in;
            for (int k = 0; k < L[i]; k++) begin
                tick();
                c++;
                chk("rnd_rise", rise_pulse, int'(e_rise[c]));
                chk("rnd_fall", fall_pulse, int'(e_fall[c]));
                chk("rnd_pv", period_valid, int'(e_pv[c]));
                chk("rnd_hp", half_period, e_hp[c]);
                chk("rnd_locked", locked, e_lk[c]);
                chk("rnd_err_pulse", err_pulse, int'(e_err[c]));
                chk("rnd_err_count", err_count, e_ec[c]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
